// File: rtl/ram16384x32_ctrl.sv
// Two-requester round-robin controller for a RAM16384X32 1RW macro with sleep management.
// Macro pins are registered; read data returns two cycles after the grant.
module ram16384x32_ctrl #(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 4,
  parameter logic [5:0]  FO_VALUE    = 6'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [13:0] addr0_i,
  input  logic [31:0] wdata0_i,
  input  logic [3:0]  be0_i,
  output logic        gnt0_o,
  output logic        rvalid0_o,
  output logic [31:0] rdata0_o,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [13:0] addr1_i,
  input  logic [31:0] wdata1_i,
  input  logic [3:0]  be1_i,
  output logic        gnt1_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata1_o,
  input  logic        sleep_req_i,
  output logic        awake_o,
  input  logic [31:0] ram_a_i,
  output logic [31:0] ram_i_o,
  output logic [13:0] ram_ia_o,
  output logic [31:0] ram_dm_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic        ram_slp_o,
  output logic [5:0]  ram_fo_o
);

  localparam logic [1:0] ST_SLEEP  = 2'd0;
  localparam logic [1:0] ST_WAKE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam int unsigned IDLE_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WAKE_W = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_CYCLES);
  localparam logic [WAKE_W-1:0] WAKE_LAST  = WAKE_W'(WAKE_CYCLES - 1);
  localparam bit                AUTO_SLEEP = (IDLE_CYCLES != 0);

  logic [1:0]        state_q, state_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              last_q, last_d;
  logic              acc1_q;
  logic [1:0]        rd1_q, rd1_d, rd2_q;
  logic              slp_q, slp_d;
  logic              ce_q, ce_d, we_q, we_d;
  logic [13:0]       ia_q, ia_d;
  logic [31:0]       i_q, i_d, dm_q, dm_d;

  logic        grant_ok, gnt0, gnt1, gnt_any, any_req, inflight;
  logic        sel_we;
  logic [13:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;

  // last_q high means requester 1 was granted most recently, so requester 0 wins a tie
  assign grant_ok = (state_q == ST_ACTIVE) && !sleep_req_i;
  assign gnt0     = grant_ok && req0_i && (!req1_i || last_q);
  assign gnt1     = grant_ok && req1_i && (!req0_i || !last_q);
  assign gnt_any  = gnt0 || gnt1;
  assign any_req  = req0_i || req1_i;
  assign inflight = gnt_any || acc1_q || (|rd2_q);

  assign sel_we    = gnt1 ? we1_i    : we0_i;
  assign sel_addr  = gnt1 ? addr1_i  : addr0_i;
  assign sel_wdata = gnt1 ? wdata1_i : wdata0_i;
  assign sel_be    = gnt1 ? be1_i    : be0_i;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = '0;
    case (state_q)
      ST_SLEEP: begin
        wake_cnt_d = '0;
        if (any_req && !sleep_req_i) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (sleep_req_i) begin
          state_d    = ST_SLEEP;
          wake_cnt_d = '0;
        end else if (wake_cnt_q == WAKE_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (any_req || inflight)       idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
        else                           idle_cnt_d = idle_cnt_q;
        if (!inflight && (sleep_req_i || (AUTO_SLEEP && idle_cnt_d == IDLE_MAX)))
          state_d = ST_SLEEP;
      end
      default: state_d = ST_SLEEP;
    endcase
  end

  always_comb begin
    last_d = last_q;
    ce_d   = 1'b1;
    we_d   = we_q;
    ia_d   = ia_q;
    i_d    = i_q;
    dm_d   = dm_q;
    rd1_d  = {gnt1 && !we1_i, gnt0 && !we0_i};
    slp_d  = (state_d != ST_SLEEP);
    if (gnt_any) begin
      last_d = gnt1;
      ce_d   = 1'b0;
      we_d   = !sel_we;
      ia_d   = sel_addr;
      i_d    = sel_wdata;
      dm_d   = sel_we ? ~{{8{sel_be[3]}}, {8{sel_be[2]}}, {8{sel_be[1]}}, {8{sel_be[0]}}} : 32'h0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_SLEEP;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      last_q     <= 1'b1;
      acc1_q     <= 1'b0;
      rd1_q      <= 2'b00;
      rd2_q      <= 2'b00;
      slp_q      <= 1'b0;
      ce_q       <= 1'b1;
      we_q       <= 1'b1;
      ia_q       <= '0;
      i_q        <= '0;
      dm_q       <= '1;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      last_q     <= last_d;
      acc1_q     <= gnt_any;
      rd1_q      <= rd1_d;
      rd2_q      <= rd1_q;
      slp_q      <= slp_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      ia_q       <= ia_d;
      i_q        <= i_d;
      dm_q       <= dm_d;
    end
  end

  assign gnt0_o    = gnt0;
  assign gnt1_o    = gnt1;
  assign rvalid0_o = rd2_q[0];
  assign rvalid1_o = rd2_q[1];
  assign rdata0_o  = rd2_q[0] ? ram_a_i : 32'h0;
  assign rdata1_o  = rd2_q[1] ? ram_a_i : 32'h0;
  assign awake_o   = (state_q == ST_ACTIVE);
  assign ram_ce_o  = ce_q;
  assign ram_we_o  = we_q;
  assign ram_ia_o  = ia_q;
  assign ram_i_o   = i_q;
  assign ram_dm_o  = dm_q;
  assign ram_slp_o = slp_q;
  assign ram_fo_o  = FO_VALUE;

endmodule

// File: tb/tb_ram16384x32_ctrl.sv
// Bench for ram16384x32_ctrl: directed scenarios then random traffic, checked against a
// word-level memory model, an abstract power-state model and a bench-side macro emulation.
`timescale 1ns/1ps
module tb_ram16384x32_ctrl;

  localparam int IDLE = 8;
  localparam int WAKE = 4;
  localparam logic [5:0] FO = 6'h15;
  localparam int PS_SLEEP = 0, PS_WAKE = 1, PS_ACTIVE = 2;

  logic        clk, rst;
  logic        reqV[2], weV[2];
  logic [13:0] addrV[2];
  logic [31:0] wdataV[2];
  logic [3:0]  beV[2];
  logic        sleepReq;
  logic        gnt0, gnt1, rvalid0, rvalid1, awake;
  logic [31:0] rdata0, rdata1;
  logic [31:0] ramA, ramI, ramDm;
  logic [13:0] ramIa;
  logic        ramCe, ramWe, ramSlp;
  logic [5:0]  ramFo;

  int vectors, miscompares;
  int cyc;
  logic sawGnt[2];

  ram16384x32_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .FO_VALUE(FO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(reqV[0]), .we0_i(weV[0]), .addr0_i(addrV[0]), .wdata0_i(wdataV[0]), .be0_i(beV[0]),
    .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
    .req1_i(reqV[1]), .we1_i(weV[1]), .addr1_i(addrV[1]), .wdata1_i(wdataV[1]), .be1_i(beV[1]),
    .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
    .sleep_req_i(sleepReq), .awake_o(awake),
    .ram_a_i(ramA), .ram_i_o(ramI), .ram_ia_o(ramIa), .ram_dm_o(ramDm),
    .ram_ce_o(ramCe), .ram_we_o(ramWe), .ram_slp_o(ramSlp), .ram_fo_o(ramFo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] maskFor(input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? 8'h00 : 8'hFF;
    return r;
  endfunction

  // Stand-in for the macro: executes whatever the registered pins present at each edge
  logic [31:0] macroMem [16384];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ramA <= 32'h0;
      for (int i = 0; i < 16384; i++) macroMem[i] = 32'h0;
    end else if (!ramCe) begin
      if (!ramWe) macroMem[ramIa] = (macroMem[ramIa] & ramDm) | (ramI & ~ramDm);
      else        ramA <= macroMem[ramIa];
    end
  end

  typedef struct {
    int          port;
    int          due;
    logic [31:0] data;
  } rdExp_t;

  logic [31:0] refMem [16384];
  rdExp_t      rdQ[$];
  rdExp_t      newRd;
  int          mState, wakeLeft, idleRun, busyUntil, mLast, mg;
  logic        mInflight, mAnyReq;
  logic        expCe, expWe;
  logic [13:0] expIa;
  logic [31:0] expI, expDm;

  function automatic int predGrant();
    if (mState != PS_ACTIVE || sleepReq) return -1;
    if (reqV[0] && reqV[1]) return (mLast == 0) ? 1 : 0;
    if (reqV[0]) return 0;
    if (reqV[1]) return 1;
    return -1;
  endfunction

  // Reference model: advances once per cycle from the inputs the DUT saw during that cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mState = PS_SLEEP; wakeLeft = 0; idleRun = 0; busyUntil = -1; mLast = 1;
      rdQ.delete();
      expCe = 1'b1; expWe = 1'b1; expIa = '0; expI = '0; expDm = '1;
      for (int i = 0; i < 16384; i++) refMem[i] = 32'h0;
    end else begin
      mg        = predGrant();
      mAnyReq   = reqV[0] || reqV[1];
      mInflight = (mg >= 0) || (cyc <= busyUntil);
      expCe     = 1'b1;
      if (mg >= 0) begin
        expCe = 1'b0;
        expWe = !weV[mg];
        expIa = addrV[mg];
        expI  = wdataV[mg];
        if (weV[mg]) begin
          expDm = maskFor(beV[mg]);
          refMem[addrV[mg]] = mergeBytes(refMem[addrV[mg]], wdataV[mg], beV[mg]);
          if (busyUntil < cyc + 1) busyUntil = cyc + 1;
        end else begin
          expDm      = 32'h0;
          newRd.port = mg;
          newRd.due  = cyc + 2;
          newRd.data = refMem[addrV[mg]];
          rdQ.push_back(newRd);
          busyUntil = cyc + 2;
        end
        mLast = mg;
      end
      if (rdQ.size() > 0 && rdQ[0].due == cyc) void'(rdQ.pop_front());
      case (mState)
        PS_SLEEP: if (mAnyReq && !sleepReq) begin mState = PS_WAKE; wakeLeft = WAKE; end
        PS_WAKE: begin
          if (sleepReq) mState = PS_SLEEP;
          else begin
            wakeLeft--;
            if (wakeLeft == 0) mState = PS_ACTIVE;
          end
        end
        default: begin
          if (mAnyReq || mInflight) idleRun = 0;
          else if (idleRun < IDLE) idleRun++;
          if (!mInflight && (sleepReq || (IDLE != 0 && idleRun == IDLE))) begin
            mState  = PS_SLEEP;
            idleRun = 0;
          end
        end
      endcase
      cyc++;
    end
  end

  int          pg;
  logic        expRv0, expRv1;
  logic [31:0] expRd0, expRd1;

  always @(negedge clk) begin
    sawGnt[0] = gnt0;
    sawGnt[1] = gnt1;
    if (!rst) begin
      pg     = predGrant();
      expRv0 = (rdQ.size() > 0) && (rdQ[0].due == cyc) && (rdQ[0].port == 0);
      expRv1 = (rdQ.size() > 0) && (rdQ[0].due == cyc) && (rdQ[0].port == 1);
      expRd0 = expRv0 ? rdQ[0].data : 32'h0;
      expRd1 = expRv1 ? rdQ[0].data : 32'h0;
      checkOutput("gnt0",    32'(gnt0),    32'(pg == 0));
      checkOutput("gnt1",    32'(gnt1),    32'(pg == 1));
      checkOutput("awake",   32'(awake),   32'(mState == PS_ACTIVE));
      checkOutput("slp",     32'(ramSlp),  32'(mState != PS_SLEEP));
      checkOutput("ce",      32'(ramCe),   32'(expCe));
      checkOutput("we",      32'(ramWe),   32'(expWe));
      checkOutput("ia",      32'(ramIa),   32'(expIa));
      checkOutput("i",       ramI,         expI);
      checkOutput("dm",      ramDm,        expDm);
      checkOutput("rvalid0", 32'(rvalid0), 32'(expRv0));
      checkOutput("rvalid1", 32'(rvalid1), 32'(expRv1));
      checkOutput("rdata0",  rdata0,       expRd0);
      checkOutput("rdata1",  rdata1,       expRd1);
      checkOutput("fo",      32'(ramFo),   32'(FO));
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gnt0"},   32'(gnt0),    32'h0);
    checkOutput({tag, "_gnt1"},   32'(gnt1),    32'h0);
    checkOutput({tag, "_rv0"},    32'(rvalid0), 32'h0);
    checkOutput({tag, "_rv1"},    32'(rvalid1), 32'h0);
    checkOutput({tag, "_rd0"},    rdata0,       32'h0);
    checkOutput({tag, "_rd1"},    rdata1,       32'h0);
    checkOutput({tag, "_awake"},  32'(awake),   32'h0);
    checkOutput({tag, "_ce"},     32'(ramCe),   32'h1);
    checkOutput({tag, "_we"},     32'(ramWe),   32'h1);
    checkOutput({tag, "_slp"},    32'(ramSlp),  32'h0);
    checkOutput({tag, "_ia"},     32'(ramIa),   32'h0);
    checkOutput({tag, "_i"},      ramI,         32'h0);
    checkOutput({tag, "_dm"},     ramDm,        32'hFFFF_FFFF);
    checkOutput({tag, "_fo"},     32'(ramFo),   32'(FO));
  endtask

  // Starts and ends just after a rising edge; reports grant wait, read latency, data and mask
  task automatic doAccess(input int port, input logic we, input logic [13:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          output int waitCyc, output int rdLat,
                          output logic [31:0] rd, output logic [31:0] dmSeen);
    bit got, gotRv;
    reqV[port] = 1'b1; weV[port] = we; addrV[port] = addr; wdataV[port] = data; beV[port] = be;
    got = 0; waitCyc = 0;
    while (!got && waitCyc < 100) begin
      @(negedge clk);
      if ((port == 0) ? gnt0 : gnt1) got = 1;
      else begin waitCyc++; @(posedge clk); #1; end
    end
    if (!got) checkOutput("gntTimeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    reqV[port] = 1'b0;
    @(negedge clk);
    dmSeen = ramDm;
    rdLat = 0; rd = 32'h0; gotRv = 0;
    if (!we) begin
      for (int i = 1; i <= 5 && !gotRv; i++) begin
        if (i > 1) @(negedge clk);
        if ((port == 0) ? rvalid0 : rvalid1) begin
          gotRv = 1; rdLat = i; rd = (port == 0) ? rdata0 : rdata1;
        end
      end
      if (!gotRv) checkOutput("rvTimeout", 32'h0, 32'h1);
    end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input int nCycles);
    int reqPct;
    reqPct = 0;
    for (int c = 0; c < nCycles; c++) begin
      if (c % 60 == 0) reqPct = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(10, 80));
      for (int k = 0; k < 2; k++) begin
        if (reqV[k] && sawGnt[k]) reqV[k] = 1'b0;
        if (!reqV[k] && int'($urandom_range(1, 100)) <= reqPct) begin
          reqV[k]   = 1'b1;
          weV[k]    = 1'($urandom_range(0, 1));
          addrV[k]  = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15));
          wdataV[k] = $urandom;
          beV[k]    = 4'($urandom);
        end
      end
      sleepReq = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) reqV[k] = 1'b0;
    sleepReq = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  int          waitC, lat, fall, lastC, rvCount, gc;
  int          seq[6];
  logic [31:0] rd, dmSeen, rvData;

  initial begin
    rst = 1'b1; sleepReq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      reqV[k] = 1'b0; weV[k] = 1'b0; addrV[k] = '0; wdataV[k] = '0; beV[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("rst");
    rst = 1'b0;

    doAccess(0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, waitC, lat, rd, dmSeen);
    checkOutput("wakeGnt", 32'(waitC), 32'(WAKE + 1));
    checkOutput("wakeDm",  dmSeen,     32'h0);

    doAccess(1, 1'b0, 14'h0010, 32'h0, 4'h0, waitC, lat, rd, dmSeen);
    checkOutput("rdLat",  32'(lat), 32'd2);
    checkOutput("rdData", rd,       32'hDEADBEEF);

    doAccess(0, 1'b1, 14'h0010, 32'h11223344, 4'b0101, waitC, lat, rd, dmSeen);
    checkOutput("beMask", dmSeen, 32'hFF00FF00);
    doAccess(1, 1'b0, 14'h0010, 32'h0, 4'h0, waitC, lat, rd, dmSeen);
    checkOutput("beData", rd, 32'hDE22BE44);

    reqV[0] = 1'b1; weV[0] = 1'b0; addrV[0] = 14'h0010;
    reqV[1] = 1'b1; weV[1] = 1'b0; addrV[1] = 14'h0020;
    lastC = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seq[i] = gnt0 ? 0 : (gnt1 ? 1 : -1);
      if (seq[i] >= 0) lastC = cyc;
      @(posedge clk); #1;
    end
    reqV[0] = 1'b0; reqV[1] = 1'b0;
    for (int i = 0; i < 6; i++) checkOutput("rrOrder", 32'(seq[i]), 32'(i % 2));

    // Last read stays in flight two cycles past its grant, then IDLE quiet cycles
    fall = -1;
    for (int i = 0; i < 40 && fall < 0; i++) begin
      @(negedge clk);
      if (!ramSlp) fall = cyc;
    end
    checkOutput("idleSleep", 32'(fall - lastC), 32'(2 + IDLE + 1));
    @(posedge clk); #1;

    reqV[0] = 1'b1; weV[0] = 1'b0; addrV[0] = 14'h0010;
    gc = -1;
    for (int i = 0; i < 20 && gc < 0; i++) begin
      @(negedge clk);
      if (gnt0) gc = cyc;
      @(posedge clk); #1;
    end
    reqV[0] = 1'b0; sleepReq = 1'b1;
    fall = -1; rvCount = 0; rvData = 32'h0; lat = -1;
    for (int i = 0; i < 10 && fall < 0; i++) begin
      @(negedge clk);
      if (rvalid0) begin rvCount++; rvData = rdata0; lat = cyc - gc; end
      if (!ramSlp) fall = cyc;
    end
    checkOutput("slpReqRvCnt",  32'(rvCount),   32'd1);
    checkOutput("slpReqRvLat",  32'(lat),       32'd2);
    checkOutput("slpReqRvData", rvData,         32'hDE22BE44);
    checkOutput("slpReqFall",   32'(fall - gc), 32'd4);
    @(posedge clk); #1;
    sleepReq = 1'b0;

    reqV[1] = 1'b1; weV[1] = 1'b0; addrV[1] = 14'h0010;
    gc = -1;
    for (int i = 0; i < 20 && gc < 0; i++) begin
      @(negedge clk);
      if (gnt1) gc = cyc;
      @(posedge clk); #1;
    end
    checkOutput("rstRdGnt", 32'(gc >= 0), 32'h1);
    reqV[1] = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetValues("asyncRst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rvCount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) rvCount++;
    end
    checkOutput("noRvAfterRst", 32'(rvCount), 32'h0);
    @(posedge clk); #1;

    applyStimulus(700);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram16384x32_ctrl.md
# ram16384x32_ctrl

Two-requester controller for one RAM16384X32 1RW macro. Arbitrates word-addressed read/write requests round-robin, converts byte enables to the macro's active-high bit mask, and drives the macro's active-low CE/WE pins from registers. A sleep manager puts the macro into sleep (SLP low) after an idle timeout or on demand, and wakes it on the next request. Sits between the SoC bus adapters and the RAM macro instance.

## Interface
- IDLE_CYCLES, 64: consecutive idle ACTIVE cycles before automatic sleep; 0 disables auto-sleep.
- WAKE_CYCLES, 4: cycles SLP is held high, with CE high, before the first access after wake; minimum 1.
- FO_VALUE, 6'h00: constant driven on the fuse bus.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req0_i / req1_i  in  1  request; held stable, with its attributes, until the matching gnt.
- we0_i / we1_i  in  1  1 = write, 0 = read.
- addr0_i / addr1_i  in  14  word address.
- wdata0_i / wdata1_i  in  32  write data.
- be0_i / be1_i  in  4  byte enables; be[k] covers bits 8k+7:8k.
- gnt0_o / gnt1_o  out  1  request accepted this cycle; combinational.
- rvalid0_o / rvalid1_o  out  1  read data valid.
- rdata0_o / rdata1_o  out  32  read data; 0 when the matching rvalid is low.
- sleep_req_i  in  1  force sleep; while high, no grants are issued.
- awake_o  out  1  high only in ACTIVE.
- ram_a_i  in  32  macro output A.
- ram_i_o  out  32  macro I. ram_ia_o  out  14  macro IA. ram_dm_o  out  32  macro DM; 1 = bit not written.
- ram_ce_o  out  1  macro CE, active-low. ram_we_o  out  1  macro WE, active-low. ram_slp_o  out  1  macro SLP; 0 = asleep.
- ram_fo_o  out  6  macro FO.

## Operation
- FSM states: SLEEP, WAKE, ACTIVE. Reset enters SLEEP.
- SLEEP -> WAKE: any req high and sleep_req_i low. WAKE -> ACTIVE: after WAKE_CYCLES cycles in WAKE. ACTIVE -> SLEEP: (sleep_req_i high, or idle count reaches IDLE_CYCLES) and no access in flight. sleep_req_i high in WAKE returns the FSM to SLEEP.
- ram_slp_o is 0 in SLEEP and 1 in WAKE and ACTIVE.
- Grants are issued only in ACTIVE with sleep_req_i low, at most one per cycle. If one requester is active, it is granted. If both are active, the requester not granted most recently wins. The pointer resets to favour requester 0.
- On a grant, the macro pins register at the clock edge: ram_ce_o=0, ram_we_o=~we, ram_ia_o=addr, ram_i_o=wdata. For a write, ram_dm_o = ~{{8{be[3]}},{8{be[2]}},{8{be[1]}},{8{be[0]}}}. For a read, ram_dm_o = 0.
- In the cycle after a grant with no new grant, ram_ce_o returns to 1 and the other pins hold their values.
- A write with be=0 is granted and issued with DM all ones; memory is unchanged.
- Idle counter: counts ACTIVE cycles with no req and no access in flight. Clears on any request or in-flight access. Saturates at IDLE_CYCLES.
- Async reset mid-access aborts the access: no rvalid, and write completion is undefined.

## Timing
- Cycle t: grant. Edge at end of t: pins register. Edge at end of t+1: macro executes and A updates. Cycle t+2: rvalid pulses for 1 cycle with rdata = ram_a_i.
- Read latency is 2 cycles from grant.
- Back-to-back grants sustain 1 access per cycle, with rvalid streams in grant order.
- Wake cost: the first grant occurs WAKE_CYCLES+1 cycles after req rises in SLEEP.
- An access is in flight from its grant cycle through cycle t+2 (read) or t+1 (write).
- Reset values: gnt 0, rvalid 0, rdata 0, awake_o 0, ram_ce_o 1, ram_we_o 1, ram_slp_o 0, ram_ia_o 0, ram_i_o 0, ram_dm_o all ones, ram_fo_o FO_VALUE.

## Test plan
- Wake path: from reset, req0 write addr 0x0010 data 0xDEADBEEF be 4'hF. Required: ram_slp_o high at cycle 1, gnt0 at cycle 5 (WAKE_CYCLES=4), then ram_ce_o=0 and ram_we_o=0 for exactly 1 cycle.
- Read latency: read addr 0x0010 on req1. Required: rvalid1 exactly 2 cycles after gnt1, with rdata1=0xDEADBEEF; rvalid0 stays 0.
- Byte mask: write 0x11223344 be 4'b0101 to 0x0010, then read. Required: ram_dm_o=0xFF00FF00 on the write, and read data 0xDE22BE44.
- Contention: req0 and req1 held high for 6 cycles. Required: grants alternate, starting with requester 0, and each rvalid returns in order.
- Idle sleep: with IDLE_CYCLES=8, stop requests. Required: ram_slp_o falls 8 cycles after the last in-flight access ends. sleep_req_i pulsed during a read: the read's rvalid still returns, then SLEEP is entered.
- Async reset: assert rst_i mid-cycle during a read. Required: all outputs take reset values immediately, and no rvalid appears afterwards.
